// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin pick of one pending FU result per cycle,
// registered broadcast of tag/data, and a sticky per-source starvation watchdog.
module cdb_arbiter #(
    parameter int N_SRC    = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int MAX_WAIT = 15,
    localparam int SRC_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int CNT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*TAG_W-1:0]  src_tag,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [SRC_W-1:0]        cdb_src,
    output logic [N_SRC-1:0]        src_grant,
    output logic                    starve_err
);

    logic [N_SRC-1:0] inflight;
    logic [SRC_W-1:0] rr_ptr;
    logic [CNT_W-1:0] wait_cnt [N_SRC];

    logic [N_SRC-1:0] eligible;
    logic             pick_valid;
    logic [SRC_W-1:0] pick_idx;
    logic [N_SRC-1:0] pick_onehot;
    logic [SRC_W-1:0] next_ptr;
    logic             any_max;

    // The source currently on the CDB still holds src_valid this edge; mask it.
    assign eligible = src_valid & ~inflight;

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (eligible[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        pick_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pick_valid && (pick_idx == SRC_W'(i))) pick_onehot[i] = 1'b1;
        end
    end

    assign next_ptr = (pick_idx == SRC_W'(N_SRC - 1)) ? '0 : pick_idx + SRC_W'(1);

    always_comb begin
        any_max = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (wait_cnt[i] == CNT_W'(MAX_WAIT)) any_max = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_src    <= '0;
            src_grant  <= '0;
            inflight   <= '0;
            rr_ptr     <= '0;
            starve_err <= 1'b0;
        end else begin
            if (pick_valid) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= src_tag[int'(pick_idx)*TAG_W +: TAG_W];
                cdb_data  <= src_data[int'(pick_idx)*DATA_W +: DATA_W];
                cdb_src   <= pick_idx;
                src_grant <= pick_onehot;
                inflight  <= pick_onehot;
                rr_ptr    <= next_ptr;
            end else begin
                cdb_valid <= 1'b0;
                src_grant <= '0;
                inflight  <= '0;
            end
            if (any_max) starve_err <= 1'b1;
        end
    end

    // Counts edges a source was eligible but lost; saturates rather than wraps.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (reset) begin
                wait_cnt[i] <= '0;
            end else if (eligible[i] && !pick_onehot[i]) begin
                if (wait_cnt[i] != CNT_W'(MAX_WAIT)) wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
            end else begin
                wait_cnt[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: FU sources modelled as holding src_valid one
// edge past their own broadcast; expected values hand-computed per vector.
module tb_cdb_arbiter;

    localparam int N_SRC    = 4;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 4;
    localparam int MAX_WAIT = 2;

    logic                    clk;
    logic                    reset;
    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC*TAG_W-1:0]  src_tag;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic [1:0]              cdb_src;
    logic [N_SRC-1:0]        src_grant;
    logic                    starve_err;

    logic [N_SRC-1:0] drop_mask;
    logic             auto_drop;
    int               n_tests;
    int               n_fail;

    cdb_arbiter #(
        .N_SRC(N_SRC), .DATA_W(DATA_W), .TAG_W(TAG_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_tag(src_tag),
        .src_data(src_data), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_src(cdb_src), .src_grant(src_grant),
        .starve_err(starve_err)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1ns after the edge. A granted source drops
    // src_valid one cycle after it sees its grant.
    task automatic step();
        @(posedge clk);
        #1;
        src_valid = src_valid & ~drop_mask;
        drop_mask = auto_drop ? src_grant : '0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        src_valid = '0;
        step();
        reset     = 1'b0;
        drop_mask = '0;
    endtask

    task automatic set_src(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        src_tag[i*TAG_W +: TAG_W]    = t;
        src_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic check_bcast(input string tag, input int s, input logic [TAG_W-1:0] t,
                               input logic [DATA_W-1:0] d);
        check({tag, "_valid"}, 64'(cdb_valid), 64'd1);
        check({tag, "_src"},   64'(cdb_src),   64'(s));
        check({tag, "_grant"}, 64'(src_grant), 64'(4'b0001 << s));
        check({tag, "_tag"},   64'(cdb_tag),   64'(t));
        check({tag, "_data"},  64'(cdb_data),  64'(d));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 64'(cdb_valid), 64'd0);
        check({tag, "_grant"}, 64'(src_grant), 64'd0);
    endtask

    initial begin
        logic [TAG_W-1:0]  t3_tag  [4];
        logic [DATA_W-1:0] t3_data [4];
        logic [1:0]        prev_src;
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        src_valid = '0;
        src_tag   = '0;
        src_data  = '0;
        drop_mask = '0;
        auto_drop = 1'b1;

        // reset held with every source requesting
        src_valid = 4'hF;
        for (int c = 0; c < 2; c++) begin
            step();
            check_idle("rst_hold");
            check("rst_hold_starve", 64'(starve_err), 64'd0);
        end
        src_valid = '0;
        reset     = 1'b0;
        drop_mask = '0;

        // single request from source 2
        set_src(2, 4'd5, 32'h12345678);
        src_valid = 4'b0100;
        step();
        check_bcast("single", 2, 4'd5, 32'h12345678);
        step();
        check_idle("single_after");
        check("single_tag_hold", 64'(cdb_tag), 64'd5);
        check("single_src_hold", 64'(cdb_src), 64'd2);

        // rr_ptr is now 3: sources 0 and 3 -> 3 first, then wrap to 0
        set_src(0, 4'd3, 32'h0000_0A0A);
        set_src(3, 4'd9, 32'hDEAD_BEEF);
        src_valid = src_valid | 4'b1001;
        step();
        check_bcast("wrap_first", 3, 4'd9, 32'hDEAD_BEEF);
        step();
        check_bcast("wrap_second", 0, 4'd3, 32'h0000_0A0A);
        step();
        check_idle("wrap_idle");
        check("wrap_starve", 64'(starve_err), 64'd0);

        // all four at once, tag 0 included; source 3 starves with MAX_WAIT=2
        do_reset();
        t3_tag  = '{4'h0, 4'h7, 4'hA, 4'hF};
        t3_data = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
        for (int i = 0; i < 4; i++) set_src(i, t3_tag[i], t3_data[i]);
        src_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            check_bcast($sformatf("all4_%0d", i), i, t3_tag[i], t3_data[i]);
            if (i == 1) check("starve_not_yet", 64'(starve_err), 64'd0);
            if (i == 2) check("starve_set", 64'(starve_err), 64'd1);
        end
        step();
        check_idle("all4_idle");
        step();
        step();
        check("starve_sticky", 64'(starve_err), 64'd1);
        do_reset();
        check("starve_cleared", 64'(starve_err), 64'd0);

        // two continuous requesters alternate
        auto_drop = 1'b0;
        src_valid = 4'b0011;
        prev_src  = 2'd3;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("alt_%0d", i), 64'(cdb_src), 64'(i % 2));
            check($sformatf("alt_valid_%0d", i), 64'(cdb_valid), 64'd1);
            check($sformatf("alt_diff_%0d", i), 64'(cdb_src != prev_src), 64'd1);
            prev_src = cdb_src;
        end
        check("alt_starve", 64'(starve_err), 64'd0);
        src_valid = '0;
        auto_drop = 1'b1;
        step();
        check_idle("alt_idle");

        // reset during a broadcast drops it and restarts the pointer
        do_reset();
        auto_drop = 1'b0;
        src_valid = 4'hF;
        step();
        check("mid_g0", 64'(cdb_src), 64'd0);
        step();
        check("mid_g1", 64'(cdb_src), 64'd1);
        reset = 1'b1;
        step();
        check_idle("mid_rst");
        check("mid_rst_starve", 64'(starve_err), 64'd0);
        reset = 1'b0;
        step();
        check("mid_restart_valid", 64'(cdb_valid), 64'd1);
        check("mid_restart_src", 64'(cdb_src), 64'd0);
        src_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
